// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared encodings for the multicycle controller
// Purpose: state encodings, opcode values, mux select codes and trap causes
//          shared by the controller and its bench.
// Ports:   none (package)
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_ACC  = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_TRAP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_TRAP   = 2'd3;

    localparam logic [1:0] SRC2_REGB   = 2'd0;
    localparam logic [1:0] SRC2_FOUR   = 2'd1;
    localparam logic [1:0] SRC2_IMM    = 2'd2;
    localparam logic [1:0] SRC2_IMM_SH = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// rtl/multicycle_ctrl_fsm_wait_timer.sv - saturating wait counter with expiry flag
// Purpose: counts cycles spent waiting on memory; flags expiry at TIMEOUT-1.
// Ports:   CLK, Reset (async, active-high), clear, enable -> expire
module ctrl_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign expire = (wait_cnt == LAST);

    // Clear wins over enable; the count stops at LAST so it can never wrap.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expire) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle datapath controller FSM
// Purpose: Moore controller sequencing fetch/decode/execute/memory/writeback,
//          with memory-ready handshake, global stall, memory timeout and
//          illegal-opcode trap.
// Ports:   CLK, Reset (async, active-high), Opcode, Zero, mem_ready, stall in;
//          PCSource, ALUsrc1, ALUsrc2, ALUOp, PCWrite, MemRead, MemWrite,
//          IRWrite, RegWrite, MemtoReg, WriteBlocker, trap, trap_cause,
//          state_dbg out.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int PCSRC_W  = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    input  logic                stall,
    output logic [PCSRC_W-1:0]  PCSource,
    output logic                ALUsrc1,
    output logic [1:0]          ALUsrc2,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                PCWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic                WriteBlocker,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state_dbg
);

    state_t              state, state_n;
    logic [OPCODE_W-1:0] op_q;
    logic [1:0]          cause_q, cause_n;
    logic                cause_we;
    logic                in_trap_d;
    logic                waiting, tmr_clear, tmr_enable, tmr_expire;

    logic op_lw_q, op_sw_q;
    assign op_lw_q = (op_q == OPCODE_W'(OP_LW));
    assign op_sw_q = (op_q == OPCODE_W'(OP_SW));

    // Only FETCH and MEM_ACC wait on memory.
    assign waiting    = (state == ST_FETCH) || (state == ST_MEM_ACC);
    // Stall freezes the counter; otherwise any completion or state exit clears it.
    assign tmr_enable = !stall && waiting && !mem_ready;
    assign tmr_clear  = !stall && (!waiting || mem_ready || (state_n != state));

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) u_wait_timer (
        .CLK    (CLK),
        .Reset  (Reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expire (tmr_expire)
    );

    // Next state. Stall holds everything; mem_ready beats an expiring timer.
    always_comb begin
        state_n  = state;
        cause_n  = cause_q;
        cause_we = 1'b0;
        if (!stall) begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_n = ST_DECODE;
                    end else if (tmr_expire) begin
                        state_n  = ST_TRAP;
                        cause_n  = CAUSE_TIMEOUT;
                        cause_we = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (Opcode == OPCODE_W'(OP_R)) begin
                        state_n = ST_EXEC_R;
                    end else if (Opcode == OPCODE_W'(OP_ADDI)) begin
                        state_n = ST_EXEC_I;
                    end else if (Opcode == OPCODE_W'(OP_LW) || Opcode == OPCODE_W'(OP_SW)) begin
                        state_n = ST_MEM_ADDR;
                    end else if (Opcode == OPCODE_W'(OP_BEQ)) begin
                        state_n = ST_BRANCH;
                    end else if (Opcode == OPCODE_W'(OP_J)) begin
                        state_n = ST_JUMP;
                    end else begin
                        state_n  = ST_TRAP;
                        cause_n  = CAUSE_ILLEGAL;
                        cause_we = 1'b1;
                    end
                end
                ST_EXEC_R, ST_EXEC_I: state_n = ST_WB_ALU;
                ST_MEM_ADDR:          state_n = ST_MEM_ACC;
                ST_MEM_ACC: begin
                    if (mem_ready) begin
                        state_n = op_lw_q ? ST_MEM_WB : ST_FETCH;
                    end else if (tmr_expire) begin
                        state_n  = ST_TRAP;
                        cause_n  = CAUSE_TIMEOUT;
                        cause_we = 1'b1;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            cause_q   <= CAUSE_NONE;
            in_trap_d <= 1'b0;
        end else begin
            state     <= state_n;
            in_trap_d <= (state == ST_TRAP);
            if (state == ST_DECODE && !stall) begin
                op_q <= Opcode;
            end
            if (cause_we) begin
                cause_q <= cause_n;
            end
        end
    end

    // Moore output decode; everything is forced low while Reset is asserted.
    always_comb begin
        PCSource     = '0;
        ALUsrc1      = 1'b0;
        ALUsrc2      = SRC2_REGB;
        ALUOp        = '0;
        PCWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemtoReg     = 1'b0;
        WriteBlocker = 1'b0;
        trap         = 1'b0;
        trap_cause   = 2'd0;
        state_dbg    = 4'd0;
        if (!Reset) begin
            state_dbg  = state;
            trap_cause = cause_q;
            case (state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUsrc2 = SRC2_FOUR;
                    ALUOp   = ALUOP_W'(ALUOP_ADD);
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_DECODE: begin
                    ALUsrc2 = SRC2_IMM_SH;
                    ALUOp   = ALUOP_W'(ALUOP_ADD);
                end
                ST_EXEC_R: begin
                    ALUsrc1 = 1'b1;
                    ALUsrc2 = SRC2_REGB;
                    ALUOp   = ALUOP_W'(ALUOP_FUNCT);
                end
                ST_EXEC_I, ST_MEM_ADDR: begin
                    ALUsrc1 = 1'b1;
                    ALUsrc2 = SRC2_IMM;
                    ALUOp   = ALUOP_W'(ALUOP_ADD);
                end
                ST_WB_ALU: RegWrite = 1'b1;
                ST_MEM_ACC: begin
                    MemRead  = op_lw_q;
                    MemWrite = op_sw_q;
                end
                ST_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_BRANCH: begin
                    ALUsrc1  = 1'b1;
                    ALUsrc2  = SRC2_REGB;
                    ALUOp    = ALUOP_W'(ALUOP_SUB);
                    PCSource = PCSRC_W'(PCSRC_BRANCH);
                    PCWrite  = Zero;
                end
                ST_JUMP: begin
                    PCSource = PCSRC_W'(PCSRC_JUMP);
                    PCWrite  = 1'b1;
                end
                ST_TRAP: begin
                    PCSource     = PCSRC_W'(PCSRC_TRAP);
                    PCWrite      = 1'b1;
                    WriteBlocker = 1'b1;
                    // A stalled TRAP lingers; the pulse marks only the entry cycle.
                    trap         = !in_trap_d;
                end
                default: ;
            endcase
            if (stall) begin
                PCWrite  = 1'b0;
                IRWrite  = 1'b0;
                RegWrite = 1'b0;
                MemWrite = 1'b0;
            end
        end
    end

endmodule
